// File: rtl/hyst_threshold_window.sv
// -----------------------------------------------------------------------------
// hyst_threshold_window
//
// Purpose:
//   Double-threshold classifier and two-line column buffer that feeds the
//   hysteresis edge-linking stage.  Each accepted gradient magnitude is
//   classified as strong (3'b100), weak (3'b010) or none (3'b000).  For every
//   pixel a vertically aligned column of class codes is emitted:
//     R0 = row n-2, R1 = row n-1, R2 = row n (current pixel).
//   Columns are flagged valid only once two complete lines of the current
//   frame have been seen.  Latency is one cycle from accepted input.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   in_data / in_sof valid this cycle (no backpressure)
//   in_sof     marks the first pixel of a frame
//   in_data    unsigned gradient magnitude, MAG_W bits
//   low_th     (HYST_THRESH_PROG_EN only) programmable weak threshold
//   high_th    (HYST_THRESH_PROG_EN only) programmable strong threshold
//   out_valid  R0/R1/R2 carry a valid column
//   out_eol    column is the last of its line
//   R0/R1/R2   class codes, oldest row to newest row
//
// Configuration macro:
//   HYST_THRESH_PROG_EN - when defined, thresholds come from the low_th /
//   high_th ports, captured on reset and on every accepted in_sof beat so they
//   are stable across a frame.  When undefined, LOW_TH / HIGH_TH are used.
// -----------------------------------------------------------------------------
module hyst_threshold_window #(
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned MAG_W   = 8,
  parameter int unsigned HIGH_TH = 100,
  parameter int unsigned LOW_TH  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [MAG_W-1:0] in_data,
`ifdef HYST_THRESH_PROG_EN
  input  logic [MAG_W-1:0] low_th,
  input  logic [MAG_W-1:0] high_th,
`endif
  output logic             out_valid,
  output logic             out_eol,
  output logic [2:0]       R0,
  output logic [2:0]       R1,
  output logic [2:0]       R2
);

  localparam int unsigned      COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  localparam logic [2:0] CODE_STRONG = 3'b100;
  localparam logic [2:0] CODE_WEAK   = 3'b010;
  localparam logic [2:0] CODE_NONE   = 3'b000;

  // ---------------------------------------------------------------------------
  // Thresholds
  // ---------------------------------------------------------------------------
  logic             sof_beat;
  logic [MAG_W-1:0] lo_eff;
  logic [MAG_W-1:0] hi_eff;

  assign sof_beat = in_valid & in_sof;

`ifdef HYST_THRESH_PROG_EN
  logic [MAG_W-1:0] low_q;
  logic [MAG_W-1:0] high_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      low_q  <= low_th;
      high_q <= high_th;
    end else if (sof_beat) begin
      low_q  <= low_th;
      high_q <= high_th;
    end
  end

  // The start-of-frame pixel already belongs to the new frame, so it sees the
  // port values directly rather than the not-yet-updated registers.
  assign lo_eff = sof_beat ? low_th  : low_q;
  assign hi_eff = sof_beat ? high_th : high_q;
`else
  assign lo_eff = MAG_W'(LOW_TH);
  assign hi_eff = MAG_W'(HIGH_TH);
`endif

  // ---------------------------------------------------------------------------
  // Classifier: strong takes priority, so an inverted threshold pair simply
  // never yields weak.
  // ---------------------------------------------------------------------------
  logic [2:0] code;

  always_comb begin
    code = CODE_NONE;
    if (in_data >= hi_eff) begin
      code = CODE_STRONG;
    end else if (in_data >= lo_eff) begin
      code = CODE_WEAK;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster position
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       rows_q, rows_d;
  logic [COL_W-1:0] col_eff;
  logic [1:0]       rows_eff;
  logic             valid_d, eol_d;

  // A start-of-frame beat restarts the raster at col 0 of row 0 regardless of
  // where the previous frame was.
  assign col_eff  = sof_beat ? '0   : col_q;
  assign rows_eff = sof_beat ? 2'd0 : rows_q;

  always_comb begin
    col_d   = col_q;
    rows_d  = rows_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    if (in_valid) begin
      valid_d = (rows_eff == 2'd2);
      eol_d   = valid_d && (col_eff == LAST_COL);
      if (col_eff == LAST_COL) begin
        col_d  = '0;
        rows_d = (rows_eff == 2'd2) ? 2'd2 : rows_eff + 2'd1;
      end else begin
        col_d  = col_eff + COL_W'(1);
        rows_d = rows_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control / current-row output registers
  // ---------------------------------------------------------------------------
  logic       valid_q, eol_q;
  logic [2:0] r2_q;
  logic       hold_zero_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      rows_q      <= 2'd0;
      valid_q     <= 1'b0;
      eol_q       <= 1'b0;
      r2_q        <= CODE_NONE;
      hold_zero_q <= 1'b1;
    end else begin
      col_q   <= col_d;
      rows_q  <= rows_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      if (in_valid) begin
        r2_q        <= code;
        hold_zero_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers.  lb1 holds the previous row, lb0 the row before it.  Both
  // are read-before-write at the same address, so one pass per pixel both
  // produces the column and shifts the rows down by one.  The read registers
  // carry no reset so the arrays map onto block RAM; the reset-state zeros on
  // R0/R1 are produced by masking instead.
  // ---------------------------------------------------------------------------
  logic [2:0] lb0_mem [IMG_W];
  logic [2:0] lb1_mem [IMG_W];
  logic [2:0] rd0_q, rd1_q;

  always_ff @(posedge clk) begin
    if (rst && in_valid) begin
      rd0_q            <= lb0_mem[col_eff];
      rd1_q            <= lb1_mem[col_eff];
      lb0_mem[col_eff] <= lb1_mem[col_eff];
      lb1_mem[col_eff] <= code;
    end
  end

  assign out_valid = valid_q;
  assign out_eol   = eol_q;
  assign R0        = hold_zero_q ? CODE_NONE : rd0_q;
  assign R1        = hold_zero_q ? CODE_NONE : rd1_q;
  assign R2        = r2_q;

endmodule
